// File: rtl/mux_seq_pkg.sv
// Shared constants, state type and select-order helpers for the 16:1 mux sequencer.
package mux_seq_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] start_sel(input bit msb_first);
        return msb_first ? 4'd15 : 4'd0;
    endfunction

    function automatic logic [SEL_W-1:0] end_sel(input bit msb_first);
        return msb_first ? 4'd0 : 4'd15;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer.sv
// Holds an accepted word on the mux data inputs and steps the mux select through all
// 16 positions, presenting the mux output as a valid/ready serial stream with a last flag.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] mux_i,
    output logic [SEL_W-1:0]  mux_s,
    input  logic              mux_y,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_data,
    output logic              ser_last,
    output logic              busy
);

    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_gap_range
        $error("mux_sel_sequencer: GAP_CYCLES must be in 0..15");
    end

    localparam logic [SEL_W-1:0] START_SEL = start_sel(MSB_FIRST);
    localparam logic [SEL_W-1:0] END_SEL   = end_sel(MSB_FIRST);
    localparam logic [3:0]       GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state;
    logic [3:0] gap_cnt;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // ser_valid never drops inside a frame; rst masks every control output immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mux_i   <= '0;
            mux_s   <= START_SEL;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mux_i <= in_data;
                        mux_s <= START_SEL;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        if (mux_s == END_SEL) begin
                            mux_s <= START_SEL;
                            if (GAP_CYCLES > 0) begin
                                state   <= GAP;
                                gap_cnt <= GAP_LOAD;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            mux_s <= MSB_FIRST ? (mux_s - 4'd1) : (mux_s + 4'd1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE)  && !rst;
    assign ser_valid = (state == SHIFT) && !rst;
    assign ser_last  = (state == SHIFT) && !rst && (mux_s == END_SEL);
    assign busy      = (state != IDLE)  && !rst;
    assign ser_data  = mux_y;

endmodule
